// File: rtl/bit_packer.sv
// bit_packer: packs a serial bit stream into DWIDTH-bit words, with flush for
// partial words and a 2-entry output FIFO carrying {data, len}.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bit_in, bit_vld    : serial data bit and its qualifier (no backpressure)
//   flush              : emit the partially filled word (includes a same-cycle bit)
//   word_data/len/vld  : FIFO head word, number of valid bits, FIFO non-empty
//   word_rdy           : consumer accepts the head word when word_vld is high
//   ovf, ovf_clr       : sticky dropped-word flag and its synchronous clear
module bit_packer #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bit_in,
  input  logic                        bit_vld,
  input  logic                        flush,
  output logic [DWIDTH-1:0]           word_data,
  output logic [$clog2(DWIDTH):0]     word_len,
  output logic                        word_vld,
  input  logic                        word_rdy,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int unsigned CW = $clog2(DWIDTH);
  localparam int unsigned LW = $clog2(DWIDTH) + 1;

  typedef struct packed {
    logic [LW-1:0]     len;
    logic [DWIDTH-1:0] data;
  } word_t;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] asm_q, asm_d;
  word_t             mem0_q, mem0_d;
  word_t             mem1_q, mem1_d;
  logic [1:0]        occ_q, occ_d;
  logic              ovf_q, ovf_d;

  logic [CW-1:0]     pos;
  logic [DWIDTH-1:0] asm_nxt;
  logic [LW-1:0]     n_eff;
  logic              full_word;
  logic              emit;
  logic              pop;
  logic              push;
  logic              drop;
  word_t             new_word;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      mem0_q  <= '0;
      mem1_q  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: assembly, word emission, FIFO push/pop, overflow flag
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    asm_nxt  = asm_q;
    new_word = '0;

    pos = (MSB_FIRST != 0) ? (CW'(DWIDTH - 1) - cnt_q) : cnt_q;
    if (bit_vld) begin
      asm_nxt[pos] = bit_in;
    end

    // Effective count includes a bit arriving this cycle, so a flush with it
    // emits that bit and a flush on an empty assembler emits nothing.
    n_eff     = LW'(cnt_q) + LW'(bit_vld);
    full_word = bit_vld && (cnt_q == CW'(DWIDTH - 1));
    emit      = full_word || (flush && (n_eff != '0));

    new_word.data = asm_nxt;
    new_word.len  = n_eff;

    pop  = (occ_q != 2'd0) && word_rdy;
    push = emit && ((occ_q != 2'd2) || pop);
    drop = emit && !push;

    // Head shifts on pop; the vacated tail slot is zeroed so an empty FIFO
    // presents zero data.
    if (pop) begin
      mem0_d = mem1_q;
      mem1_d = '0;
    end
    if (push) begin
      if ((occ_q - 2'(pop)) == 2'd0) begin
        mem0_d = new_word;
      end else begin
        mem1_d = new_word;
      end
    end
    occ_d = occ_q - 2'(pop) + 2'(push);

    // Set wins over clear
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (emit) begin
      cnt_d   = '0;
      asm_d   = '0;
      state_d = IDLE;
    end else if (bit_vld) begin
      cnt_d   = cnt_q + CW'(1);
      asm_d   = asm_nxt;
      state_d = FILL;
    end
  end

  assign word_vld  = (occ_q != 2'd0);
  assign word_data = mem0_q.data;
  assign word_len  = mem0_q.len;
  assign ovf       = ovf_q;

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning output word width in bits (legal range 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning that 1 places the first serial bit at word bit DWIDTH-1 and 0 places it at bit 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port bit_in, input, 1 bit: serial data bit, driven by the upstream registered douty stage.
REQ-006 SHALL have port bit_vld, input, 1 bit: bit_in is valid this cycle; there is no backpressure on this interface.
REQ-007 SHALL have port flush, input, 1 bit: emit the partially filled word.
REQ-008 SHALL have port word_data, output, DWIDTH bits: head-of-buffer word.
REQ-009 SHALL have port word_len, output, $clog2(DWIDTH)+1 bits: number of valid bits in word_data (1..DWIDTH).
REQ-010 SHALL have port word_vld, output, 1 bit: the output buffer is non-empty.
REQ-011 SHALL have port word_rdy, input, 1 bit: the consumer accepts the word; a transfer occurs when word_vld and word_rdy are both high.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag indicating a word was dropped.
REQ-013 SHALL have port ovf_clr, input, 1 bit: synchronous clear of ovf.

Function
REQ-014 SHALL hold an assembly register asm_q[DWIDTH-1:0] and a bit count cnt in the range 0..DWIDTH-1.
REQ-015 SHALL, when bit_vld is high, write bit_in to position DWIDTH-1-cnt if MSB_FIRST=1, or to position cnt if MSB_FIRST=0, and then increment cnt.
REQ-016 SHALL write zeros to all unfilled positions of asm_q; asm_q SHALL clear to 0 whenever a word is emitted.
REQ-017 SHALL, when bit_vld is high with cnt==DWIDTH-1, emit a full word: data = asm_q including the new bit, len = DWIDTH; cnt wraps to 0.
REQ-018 SHALL, when flush is high and the effective count n > 0, emit a partial word with len = n, unfilled bits 0, and cnt returning to 0.
REQ-019 SHALL define the effective count n as cnt plus 1 if bit_vld is high in the same cycle; a same-cycle bit_vld bit is included in the flushed word.
REQ-020 SHALL treat flush with n == 0 as a no-op: no word is emitted.
REQ-021 SHALL, when flush is high on the same cycle that a word completes, emit exactly one full word (len = DWIDTH) and no empty word.
REQ-022 SHALL implement a 2-entry output FIFO holding {data, len}.
REQ-023 SHALL drive word_vld as FIFO non-empty, and word_data and word_len from the FIFO head.
REQ-024 SHALL have a latency of 1 cycle: the word appears at word_vld/word_data on the cycle after the completing bit or flush, provided the FIFO was empty.
REQ-025 SHALL hold word_data and word_len stable while word_vld is high and word_rdy is low.
REQ-026 SHALL accept an emitted word into a full FIFO if a pop occurs in the same cycle (simultaneous push and pop).
REQ-027 SHALL drop an emitted word if the FIFO is full with no pop; the FIFO contents are then unchanged and ovf is set to 1 on the next cycle.
REQ-028 SHALL keep ovf set until ovf_clr is high; if ovf_clr and a drop coincide, ovf SHALL remain 1 (set wins).
REQ-029 SHALL continue bit assembly unaffected by a full FIFO or by a drop.
REQ-030 SHALL track a two-state FSM: IDLE (cnt==0) and FILL (cnt>0).
REQ-031 SHALL transition the FSM as follows: IDLE->FILL on bit_vld without word completion; FILL->IDLE on word emission.

Reset
REQ-032 SHALL, while rst_n is low, immediately force: cnt=0, asm_q=0, FIFO empty, word_vld=0, word_data=0, word_len=0, ovf=0, FSM=IDLE.
REQ-033 SHALL discard any partial word and any buffered words on reset asserted mid-operation; these SHALL NOT be emitted after release.
REQ-034 SHALL accept a new bit_vld on the first clk posedge after rst_n deasserts.

Verification (DWIDTH=32 unless noted)
REQ-035 SHALL cover: 32 consecutive bits of 0xA5A50F0F MSB-first with word_rdy=1 -> one cycle after the 32nd bit, word_vld=1, word_data=0xA5A50F0F, word_len=32, for one cycle.
REQ-036 SHALL cover: bits 1,0,1,1,0 then flush -> word_data=0xB0000000, word_len=5; a second flush -> no word.
REQ-037 SHALL cover: word_rdy=0 with three full words pushed -> the first two are held in order and the third is dropped, ovf=1; after ovf_clr, ovf=0; after word_rdy=1, exactly two words are delivered.
REQ-038 SHALL cover: flush asserted together with the 32nd bit -> exactly one word with word_len=32, and cnt=0 afterwards.
REQ-039 SHALL cover: rst_n pulsed low after 10 bits, with one word buffered -> word_vld=0 immediately; the next 32 bits form a clean word with no residue.
REQ-040 SHALL cover: MSB_FIRST=0, bits 1,1,0,1 then flush -> word_data=0x0000000B, word_len=4.
